// File: rtl/sd_spi_init_seq.sv
`timescale 1ns/1ps
// SD card SPI-mode initialisation sequencer.
// Drives a byte-level SPI engine through: INIT_BYTES dummy bytes (CS high),
// CMD0, CMD8, CMD55/ACMD41 polling, CMD58. Reports capacity class and error.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start                 start pulse (accepted when not busy)
//   o_busy/o_done/o_err     status; done/err sticky until next start
//   o_err_code[2:0]         1 CMD0, 2 CMD8, 3 timeout, 4 ACMD41, 5 CMD58
//   o_sdhc                  OCR CCS bit from CMD58
//   o_cs                    card chip-select, active low
//   o_req/o_txbyte          byte request and data to the SPI engine
//   i_ack/i_rxbyte          transfer-complete pulse and received byte
module sd_spi_init_seq #(
  parameter int INIT_BYTES   = 10,
  parameter int RESP_TIMEOUT = 8,
  parameter int ACMD41_RETRY = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [2:0] o_err_code,
  output logic       o_sdhc,
  output logic       o_cs,
  output logic       o_req,
  output logic [7:0] o_txbyte,
  input  logic       i_ack,
  input  logic [7:0] i_rxbyte
);

  typedef enum logic [2:0] {
    S_IDLE, S_DUMMY, S_CMD, S_RESP, S_TAIL, S_GAP, S_DONE, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58
  } cmd_t;

  state_t      state;
  cmd_t        cmd;
  logic [15:0] cnt;
  logic [15:0] acmd_cnt;
  logic [7:0]  r1;
  logic        ocr_ccs;
  logic [11:0] echo;

  cmd_t        nxt_cmd;
  logic        nxt_fail;
  logic        nxt_done;
  logic [2:0]  nxt_code;
  logic [15:0] acmd_inc;

  function automatic logic [7:0] frame_byte(input cmd_t c, input logic [2:0] i);
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  crc;
    logic [7:0]  b;
    idx = 6'd0;
    arg = '0;
    crc = 8'hFF;
    case (c)
      C_CMD0:   begin idx = 6'd0;  arg = 32'h0000_0000; crc = 8'h95; end
      C_CMD8:   begin idx = 6'd8;  arg = 32'h0000_01AA; crc = 8'h87; end
      C_CMD55:  begin idx = 6'd55; arg = 32'h0000_0000; crc = 8'h65; end
      C_ACMD41: begin idx = 6'd41; arg = 32'h4000_0000; crc = 8'h77; end
      C_CMD58:  begin idx = 6'd58; arg = 32'h0000_0000; crc = 8'hFD; end
      default:  begin idx = 6'd0;  arg = '0;            crc = 8'hFF; end
    endcase
    case (i)
      3'd0:    b = {2'b01, idx};
      3'd1:    b = arg[31:24];
      3'd2:    b = arg[23:16];
      3'd3:    b = arg[15:8];
      3'd4:    b = arg[7:0];
      3'd5:    b = crc;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  // Result evaluation for the command just completed (used in GAP).
  always_comb begin
    acmd_inc = (acmd_cnt == '1) ? acmd_cnt : acmd_cnt + 16'd1;
    nxt_cmd  = cmd;
    nxt_fail = 1'b0;
    nxt_done = 1'b0;
    nxt_code = 3'd0;
    case (cmd)
      C_CMD0:
        if (r1 == 8'h01) nxt_cmd = C_CMD8;
        else begin nxt_fail = 1'b1; nxt_code = 3'd1; end
      C_CMD8:
        if (r1 == 8'h01 && echo == 12'h1AA) nxt_cmd = C_CMD55;
        else begin nxt_fail = 1'b1; nxt_code = 3'd2; end
      C_CMD55:
        if (r1 == 8'h00 || r1 == 8'h01) nxt_cmd = C_ACMD41;
        else begin nxt_fail = 1'b1; nxt_code = 3'd4; end
      C_ACMD41:
        if (r1 == 8'h00) nxt_cmd = C_CMD58;
        else if (r1 == 8'h01) begin
          if (acmd_inc == 16'(ACMD41_RETRY)) begin nxt_fail = 1'b1; nxt_code = 3'd4; end
          else nxt_cmd = C_CMD55;
        end
        else begin nxt_fail = 1'b1; nxt_code = 3'd4; end
      C_CMD58:
        if (r1 == 8'h00) nxt_done = 1'b1;
        else begin nxt_fail = 1'b1; nxt_code = 3'd5; end
      default: nxt_fail = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cmd        <= C_CMD0;
      cnt        <= '0;
      acmd_cnt   <= '0;
      r1         <= '1;
      ocr_ccs    <= 1'b0;
      echo       <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= '0;
      o_sdhc     <= 1'b0;
      o_cs       <= 1'b1;
      o_req      <= 1'b0;
      o_txbyte   <= 8'hFF;
    end else if (state == S_IDLE || state == S_DONE || state == S_ERR) begin
      if (i_start) begin
        state      <= S_DUMMY;
        cnt        <= '0;
        acmd_cnt   <= '0;
        o_busy     <= 1'b1;
        o_done     <= 1'b0;
        o_err      <= 1'b0;
        o_err_code <= '0;
        o_sdhc     <= 1'b0;
        o_cs       <= 1'b1;
        o_txbyte   <= 8'hFF;
        o_req      <= 1'b1;
      end
    end else if (!o_req) begin
      // One idle cycle after each ack, then the next byte is requested.
      o_req <= 1'b1;
    end else if (i_ack) begin
      o_req <= 1'b0;
      case (state)
        S_DUMMY:
          if (cnt == 16'(INIT_BYTES - 1)) begin
            state    <= S_CMD;
            cmd      <= C_CMD0;
            cnt      <= '0;
            o_cs     <= 1'b0;
            o_txbyte <= frame_byte(C_CMD0, 3'd0);
          end else cnt <= cnt + 16'd1;
        S_CMD:
          if (cnt == 16'd5) begin
            state    <= S_RESP;
            cnt      <= '0;
            o_txbyte <= 8'hFF;
          end else begin
            cnt      <= cnt + 16'd1;
            o_txbyte <= frame_byte(cmd, cnt[2:0] + 3'd1);
          end
        S_RESP:
          if (!i_rxbyte[7]) begin
            r1  <= i_rxbyte;
            cnt <= '0;
            if (cmd == C_CMD8 || cmd == C_CMD58) state <= S_TAIL;
            else begin
              state <= S_GAP;
              o_cs  <= 1'b1;
            end
          end else if (cnt == 16'(RESP_TIMEOUT - 1)) begin
            state      <= S_ERR;
            o_busy     <= 1'b0;
            o_err      <= 1'b1;
            o_err_code <= 3'd3;
            o_cs       <= 1'b1;
          end else cnt <= cnt + 16'd1;
        S_TAIL: begin
          // Only the bits that are evaluated are kept: CCS (bit 30, first
          // byte) and the CMD8 echo (bits 11:0, last two bytes).
          if (cnt == 16'd0) ocr_ccs <= i_rxbyte[6];
          if (cnt == 16'd2) echo[11:8] <= i_rxbyte[3:0];
          if (cnt == 16'd3) begin
            echo[7:0] <= i_rxbyte;
            state     <= S_GAP;
            cnt       <= '0;
            o_cs      <= 1'b1;
          end else cnt <= cnt + 16'd1;
        end
        S_GAP: begin
          if (cmd == C_ACMD41 && r1 == 8'h01) acmd_cnt <= acmd_inc;
          if (nxt_fail) begin
            state      <= S_ERR;
            o_busy     <= 1'b0;
            o_err      <= 1'b1;
            o_err_code <= nxt_code;
          end else if (nxt_done) begin
            state  <= S_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_sdhc <= ocr_ccs;
          end else begin
            state    <= S_CMD;
            cmd      <= nxt_cmd;
            cnt      <= '0;
            o_cs     <= 1'b0;
            o_txbyte <= frame_byte(nxt_cmd, 3'd0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_init_seq.sv
`timescale 1ns/1ps
// Directed bench for sd_spi_init_seq with a behavioural SD card responder.
module tb_sd_spi_init_seq;

  logic       i_clk    = 1'b0;
  logic       i_rst    = 1'b1;
  logic       i_start  = 1'b0;
  logic       i_ack    = 1'b0;
  logic [7:0] i_rxbyte = 8'hFF;
  logic       o_busy, o_done, o_err, o_sdhc, o_cs, o_req;
  logic [2:0] o_err_code;
  logic [7:0] o_txbyte;

  always #5 i_clk = ~i_clk;

  sd_spi_init_seq #(
    .INIT_BYTES  (10),
    .RESP_TIMEOUT(8),
    .ACMD41_RETRY(4)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_err_code(o_err_code),
    .o_sdhc    (o_sdhc),
    .o_cs      (o_cs),
    .o_req     (o_req),
    .o_txbyte  (o_txbyte),
    .i_ack     (i_ack),
    .i_rxbyte  (i_rxbyte)
  );

  int checks = 0;
  int errors = 0;

  // Scenario configuration (written by the stimulus thread only).
  int          scen_id     = 0;
  bit          silent_cmd0 = 1'b0;
  bit          acmd_stuck  = 1'b0;
  logic [31:0] cfg_tail8   = 32'h0000_01AA;
  logic [31:0] cfg_ocr     = 32'hC0FF_8000;
  bit          spur_en     = 1'b0;
  bit          spur_req    = 1'b0;
  bit          stop_en     = 1'b0;
  logic [7:0]  stop_byte   = 8'h01;

  // Card model observations (written by the responder thread only).
  int          dummy_cnt, poll_cnt, cmd55_cnt, acmd41_cnt, cmd_pos, hs_viol;
  logic [47:0] cur;
  logic [7:0]  resp_q[$];
  logic [47:0] frame_log[$];

  logic [47:0] exp_frames [9] = '{
    48'h40_00_00_00_00_95, 48'h48_00_00_01_AA_87, 48'h77_00_00_00_00_65,
    48'h69_40_00_00_00_77, 48'h77_00_00_00_00_65, 48'h69_40_00_00_00_77,
    48'h77_00_00_00_00_65, 48'h69_40_00_00_00_77, 48'h7A_00_00_00_00_FD};

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    dummy_cnt  = 0;
    poll_cnt   = 0;
    cmd55_cnt  = 0;
    acmd41_cnt = 0;
    cmd_pos    = 0;
    hs_viol    = 0;
    cur        = '0;
    resp_q.delete();
    frame_log.delete();
  endtask

  task automatic card_xfer(input logic [7:0] tx, input logic cs, output logic [7:0] rx);
    logic [5:0] idx;
    rx = 8'hFF;
    if (cs) begin
      cmd_pos = 0;
      if (frame_log.size() == 0) dummy_cnt++;
    end else if (cmd_pos < 6) begin
      cur = {cur[39:0], tx};
      cmd_pos++;
      if (cmd_pos == 6) begin
        frame_log.push_back(cur);
        idx = cur[45:40];
        case (idx)
          6'd0: if (!silent_cmd0) begin
            resp_q.push_back(8'hFF);
            resp_q.push_back(8'h01);
          end
          6'd8: begin
            resp_q.push_back(8'hFF);
            resp_q.push_back(8'h01);
            resp_q.push_back(cfg_tail8[31:24]);
            resp_q.push_back(cfg_tail8[23:16]);
            resp_q.push_back(cfg_tail8[15:8]);
            resp_q.push_back(cfg_tail8[7:0]);
          end
          6'd55: begin
            cmd55_cnt++;
            resp_q.push_back(8'h01);
          end
          6'd41: begin
            acmd41_cnt++;
            resp_q.push_back(8'hFF);
            resp_q.push_back((acmd_stuck || acmd41_cnt < 3) ? 8'h01 : 8'h00);
          end
          6'd58: begin
            resp_q.push_back(8'h00);
            resp_q.push_back(cfg_ocr[31:24]);
            resp_q.push_back(cfg_ocr[23:16]);
            resp_q.push_back(cfg_ocr[15:8]);
            resp_q.push_back(cfg_ocr[7:0]);
          end
          default: ;
        endcase
      end
    end else begin
      poll_cnt++;
      if (resp_q.size() > 0) rx = resp_q.pop_front();
    end
  endtask

  // SPI engine + card responder; alternates 1- and 2-cycle ack latency.
  initial begin
    logic [7:0] tx_s, rx;
    logic       cs_s;
    bit         slow;
    int         seen;
    slow = 1'b0;
    seen = -1;
    model_clear();
    forever begin
      @(negedge i_clk);
      if (seen != scen_id) begin
        model_clear();
        seen = scen_id;
      end
      if (spur_req && o_req === 1'b0) begin
        i_rxbyte = 8'h00;
        i_ack    = 1'b1;
        @(negedge i_clk);
        i_ack    = 1'b0;
        i_rxbyte = 8'hFF;
      end else if (!i_rst && o_req === 1'b1 &&
                   !(stop_en && o_cs === 1'b0 && o_txbyte === stop_byte)) begin
        tx_s = o_txbyte;
        cs_s = o_cs;
        if (slow) begin
          @(negedge i_clk);
          if (o_req !== 1'b1 || o_txbyte !== tx_s || o_cs !== cs_s) hs_viol++;
        end
        slow = ~slow;
        card_xfer(tx_s, cs_s, rx);
        i_rxbyte = rx;
        i_ack    = 1'b1;
        @(negedge i_clk);
        if (o_req !== 1'b0) hs_viol++;
        if (spur_en) begin
          i_rxbyte = 8'h00;
          @(negedge i_clk);
        end
        i_ack    = 1'b0;
        i_rxbyte = 8'hFF;
      end
    end
  end

  task automatic run_seq(input string tag, input int busy_start_at);
    bit fin;
    fin = 1'b0;
    scen_id++;
    repeat (3) @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk({tag, " start busy"}, o_busy, 1'b1);
    chk({tag, " start req"}, o_req, 1'b1);
    chk({tag, " start done clr"}, o_done, 1'b0);
    chk({tag, " start sdhc clr"}, o_sdhc, 1'b0);
    for (int c = 0; c < 20000 && !fin; c++) begin
      @(negedge i_clk);
      i_start = (c == busy_start_at) ? 1'b1 : 1'b0;
      if (o_done || o_err) fin = 1'b1;
    end
    i_start = 1'b0;
    chk({tag, " finished"}, fin, 1'b1);
  endtask

  task automatic chk_frames(input string tag);
    chk({tag, " frame count"}, frame_log.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < frame_log.size()) chk($sformatf("%s frame%0d", tag, i), frame_log[i], exp_frames[i]);
  endtask

  initial begin
    bit hit;
    #500_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
    hit = 1'b0;
  end

  initial begin
    bit hit;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst cs", o_cs, 1'b1);
    chk("rst req", o_req, 1'b0);
    chk("rst txbyte", o_txbyte, 8'hFF);
    chk("rst busy", o_busy, 1'b0);
    chk("rst done", o_done, 1'b0);
    chk("rst err", o_err, 1'b0);
    chk("rst code", o_err_code, 3'd0);
    chk("rst sdhc", o_sdhc, 1'b0);

    // Spurious ack while idle.
    #1 spur_req = 1'b1;
    @(negedge i_clk);
    #1 spur_req = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("spur req", o_req, 1'b0);
    chk("spur busy", o_busy, 1'b0);
    chk("spur done", o_done, 1'b0);

    // Nominal SDHC, with spurious acks during every idle handshake cycle.
    spur_en = 1'b1;
    run_seq("sdhc", -1);
    chk("sdhc done", o_done, 1'b1);
    chk("sdhc err", o_err, 1'b0);
    chk("sdhc code", o_err_code, 3'd0);
    chk("sdhc flag", o_sdhc, 1'b1);
    chk("sdhc busy", o_busy, 1'b0);
    chk("sdhc cs", o_cs, 1'b1);
    chk("sdhc req", o_req, 1'b0);
    chk("sdhc txbyte", o_txbyte, 8'hFF);
    chk("sdhc dummy", dummy_cnt, 10);
    chk("sdhc acmd41", acmd41_cnt, 3);
    chk_frames("sdhc");
    chk("sdhc handshake", hs_viol, 0);
    spur_en = 1'b0;

    // SDSC.
    cfg_ocr = 32'h80FF_8000;
    run_seq("sdsc", -1);
    chk("sdsc done", o_done, 1'b1);
    chk("sdsc flag", o_sdhc, 1'b0);
    chk("sdsc code", o_err_code, 3'd0);
    chk("sdsc handshake", hs_viol, 0);

    // Response timeout after CMD0.
    silent_cmd0 = 1'b1;
    run_seq("tmo", -1);
    chk("tmo err", o_err, 1'b1);
    chk("tmo done", o_done, 1'b0);
    chk("tmo code", o_err_code, 3'd3);
    chk("tmo cs", o_cs, 1'b1);
    chk("tmo req", o_req, 1'b0);
    chk("tmo busy", o_busy, 1'b0);
    chk("tmo polls", poll_cnt, 8);
    chk("tmo frames", frame_log.size(), 1);
    silent_cmd0 = 1'b0;

    // CMD8 echo mismatch.
    cfg_tail8 = 32'h0000_01AB;
    run_seq("echo", -1);
    chk("echo err", o_err, 1'b1);
    chk("echo code", o_err_code, 3'd2);
    chk("echo cmd55", cmd55_cnt, 0);
    chk("echo frames", frame_log.size(), 2);
    cfg_tail8 = 32'h0000_01AA;

    // ACMD41 never leaves idle.
    acmd_stuck = 1'b1;
    run_seq("stuck", -1);
    chk("stuck err", o_err, 1'b1);
    chk("stuck code", o_err_code, 3'd4);
    chk("stuck acmd41", acmd41_cnt, 4);
    chk("stuck cmd55", cmd55_cnt, 4);
    acmd_stuck = 1'b0;

    // Asynchronous reset while CMD8 byte 3 (0x01) is being requested.
    cfg_ocr = 32'hC0FF_8000;
    stop_en = 1'b1;
    scen_id++;
    repeat (3) @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge i_clk);
      if (o_req === 1'b1 && o_cs === 1'b0 && o_txbyte === 8'h01) hit = 1'b1;
    end
    chk("arst reached cmd8", hit, 1'b1);
    #2 i_rst = 1'b1;
    #1;
    chk("arst req", o_req, 1'b0);
    chk("arst cs", o_cs, 1'b1);
    chk("arst busy", o_busy, 1'b0);
    chk("arst txbyte", o_txbyte, 8'hFF);
    @(negedge i_clk);
    i_rst   = 1'b0;
    stop_en = 1'b0;

    // Restart from DUMMY; a start pulse mid-sequence must be ignored.
    run_seq("restart", 15);
    chk("restart done", o_done, 1'b1);
    chk("restart flag", o_sdhc, 1'b1);
    chk("restart dummy", dummy_cnt, 10);
    chk_frames("restart");
    chk("restart handshake", hs_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_spi_init_seq.md
Name: sd_spi_init_seq

Overview:
- Hardware sequencer that brings an SD card from power-up to data-transfer state over SPI mode.
- Issues the standard init sequence through a full-duplex byte-level SPI engine: 80 dummy clocks, CMD0, CMD8, then CMD55/ACMD41 polling, then CMD58.
- Reports card capacity class (SDHC/SDSC) and an error code.
- Sits between the SD-card controller register block and the SPI shifter that drives the card's CS/SCLK/MOSI/MISO pins.

Parameters:
- INIT_BYTES, 10, number of 0xFF bytes sent with CS high before CMD0 (10 bytes = 80 clocks).
- RESP_TIMEOUT, 8, maximum bytes polled for an R1 response (bit7=0) before declaring a timeout.
- ACMD41_RETRY, 1000, maximum ACMD41 attempts before giving up.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle pulse; starts the sequence
- o_busy  out  1  sequence in progress
- o_done  out  1  init succeeded; sticky until the next accepted i_start
- o_err  out  1  init failed; sticky until the next accepted i_start
- o_err_code  out  3  0 none, 1 CMD0 bad R1, 2 CMD8 bad R1/echo, 3 response timeout, 4 ACMD41 retries exhausted, 5 CMD58 bad R1
- o_sdhc  out  1  OCR CCS bit (bit30) captured from the CMD58 response
- o_cs  out  1  SD chip-select, active low
- o_req  out  1  byte transfer request to the SPI engine
- o_txbyte  out  8  byte to shift out; valid while o_req=1
- i_ack  in  1  one-cycle pulse; transfer complete
- i_rxbyte  in  8  byte shifted in; valid when i_ack=1

Behaviour:
- Reset: asynchronous, effective mid-operation. All outputs go immediately to their reset values: o_cs=1, o_req=0, o_txbyte=0xFF, o_busy=0, o_done=0, o_err=0, o_err_code=0, o_sdhc=0. Every counter is cleared and the FSM returns to IDLE.
- Handshake:
  - o_req rises and stays high, with o_txbyte stable, until the cycle i_ack=1.
  - o_req is low on the cycle after i_ack; the next request may rise on the cycle after that.
  - i_ack while o_req=0 is ignored.
- i_start:
  - Accepted in IDLE, DONE or ERR. Acceptance clears o_done, o_err, o_err_code and o_sdhc.
  - o_busy=1 and o_req=1 on the next cycle.
  - Ignored while o_busy=1.
- FSM states: IDLE, DUMMY, CMD, RESP, TAIL, GAP, DONE, ERR.
  - DUMMY: send INIT_BYTES bytes of 0xFF with o_cs=1, then go to CMD(CMD0).
  - CMD: o_cs=0; send 6 bytes: 0x40|idx, arg[31:24..7:0] MSB first, then a fixed CRC byte. CRC bytes: CMD0 0x95, CMD8 0x87, CMD55 0x65, ACMD41 0x77, CMD58 0xFD.
  - RESP: send 0xFF and poll i_rxbyte. The first byte with bit7=0 is R1. If RESP_TIMEOUT bytes pass with bit7=1 -> ERR code 3.
  - TAIL: CMD8 and CMD58 only; 4 more 0xFF bytes capturing a 32-bit word, MSB first.
  - GAP: one 0xFF byte with o_cs=1, then evaluate the result and select the next command.
- Command sequence and evaluation:
  - CMD0, arg 0: R1 must be 0x01, else code 1.
  - CMD8, arg 0x000001AA: R1 must be 0x01 and tail[11:0] must be 0x1AA, else code 2.
  - CMD55, arg 0: R1 must be 0x00 or 0x01, else code 4.
  - ACMD41, arg 0x40000000:
    - R1=0x00 -> CMD58.
    - R1=0x01 -> increment the attempt counter. If the counter equals ACMD41_RETRY -> code 4, else go back to CMD55.
    - Any other R1 -> code 4.
    - The attempt counter is 16 bits and saturates.
  - CMD58, arg 0: R1 must be 0x00, else code 5. On success o_sdhc=tail[30].
- Exit states:
  - DONE: o_done=1, o_busy=0, o_cs=1.
  - ERR: o_err=1 with the code, o_busy=0, o_cs=1. Entered directly from RESP on timeout; otherwise entered after GAP.
  - In both states o_req=0 and the o_txbyte reset value is restored.

Test Plan:
- Nominal SDHC: card model answers CMD0 0x01; CMD8 0x01+0x000001AA; ACMD41 0x01, 0x01, 0x00; CMD58 0x00+0xC0FF8000 -> o_done=1, o_sdhc=1, o_err_code=0. Exactly 10 dummy bytes and 3 ACMD41 frames are observed, and every frame byte matches the expected encoding, e.g. CMD8 = 48 00 00 01 AA 87.
- SDSC: same as nominal but OCR=0x80FF8000 -> o_done=1, o_sdhc=0.
- Timeout: card returns 0xFF forever after CMD0 -> exactly 8 poll bytes, then o_err=1, o_err_code=3, o_cs=1, o_req=0.
- CMD8 echo mismatch: tail=0x000001AB -> o_err_code=2, and no CMD55 is sent.
- ACMD41 stuck: ACMD41_RETRY=4, card always returns 0x01 -> 4 ACMD41 frames, then o_err_code=4.
- Reset and handshake: assert i_rst mid-CMD8 byte 3 -> o_req=0 and o_cs=1 in the same cycle, with no clock edge needed. A new i_start restarts from DUMMY. i_start while busy has no effect. A spurious i_ack with o_req=0 is ignored.
